video_timing_ctrl: RTL and testbench

- Sequences the HDMI/DVI transmit datapath: generates 640x480@60 raster timing at clk_pixel (25.2 MHz).
- Issues pixel fetch requests with coordinates to the pixel source (framebuffer/constellation renderer).
- Re-aligns returned pixels with delayed hsync/vsync/de, then drives the TMDS transmitter's rgb/hsync/vsync/de inputs.
- Supports clean start/stop on frame boundaries.

---
 rtl/video_timing_ctrl.sv | 171 +++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the HDMI/DVI transmit path.
// Issues pixel fetches and re-aligns returned pixels with sync/de.
module video_timing_ctrl #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter bit HS_ACTIVE_HIGH = 1'b0,
    parameter bit VS_ACTIVE_HIGH = 1'b0,
    parameter int PIPE_LAT       = 2
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        enable,
    output logic        req,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        sof,
    output logic        sol,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        running,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE + H_FP + H_SYNC >= H_TOTAL) begin : g_bad_h
        $error("hsync must end before the line wraps");
    end
    if (V_ACTIVE + V_FP + V_SYNC >= V_TOTAL) begin : g_bad_v
        $error("vsync must end before the frame wraps");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_lat
        $error("PIPE_LAT must be within 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP
    } state_e;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } ent_t;

    state_e            state_q, state_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              req_q, sof_q, sol_q;
    logic [9:0]        x_q, y_q;
    ent_t [PIPE_LAT:0] pipe_q;
    logic [23:0]       rgb_q;
    logic              de_q, hs_q, vs_q, run_q;
    logic [15:0]       fc_q;

    logic issue, last, active;
    ent_t cur;

    assign issue  = (state_q != S_IDLE) || enable;
    assign last   = (h_q == H_LAST) && (v_q == V_LAST);
    assign active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign cur    = '{act: active,
                      hs:  (h_q >= HS_BEG) && (h_q < HS_END),
                      vs:  (v_q >= VS_BEG) && (v_q < VS_END)};

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (issue) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        // A stop request only takes effect on the last position of a frame.
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (!enable) state_d = S_STOP;
            S_STOP: begin
                if (enable)    state_d = S_RUN;
                else if (last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            req_q   <= 1'b0;
            sof_q   <= 1'b0;
            sol_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pipe_q  <= '0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hs_q    <= !HS_ACTIVE_HIGH;
            vs_q    <= !VS_ACTIVE_HIGH;
            run_q   <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            run_q   <= (state_d != S_IDLE);
            if (issue) begin
                req_q     <= active;
                x_q       <= 10'(h_q);
                y_q       <= 10'(v_q);
                sof_q     <= (h_q == '0) && (v_q == '0);
                sol_q     <= (h_q == '0);
                pipe_q[0] <= cur;
                if (last) fc_q <= fc_q + 16'd1;
            end else begin
                req_q     <= 1'b0;
                sof_q     <= 1'b0;
                sol_q     <= 1'b0;
                pipe_q[0] <= '0;
            end
            for (int k = 1; k <= PIPE_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
            de_q  <= pipe_q[PIPE_LAT].act;
            hs_q  <= pipe_q[PIPE_LAT].hs ^ !HS_ACTIVE_HIGH;
            vs_q  <= pipe_q[PIPE_LAT].vs ^ !VS_ACTIVE_HIGH;
            rgb_q <= pipe_q[PIPE_LAT].act ? rgb_in : 24'h000000;
        end
    end

    assign req         = req_q;
    assign x           = x_q;
    assign y           = y_q;
    assign sof         = sof_q;
    assign sol         = sol_q;
    assign rgb_out     = rgb_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign running     = run_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a reduced raster (32x15 totals)
// against a linear-position reference model.
module tb_video_timing_ctrl;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 8, VFP = 2, VS = 2, VBP = 3;
    localparam int LAT = 2;
    localparam bit HSH = 1'b0, VSH = 1'b1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        req, sof, sol, hsync, vsync, de, running;
    logic [9:0]  x, y;
    logic [23:0] rgb_in = 24'hFFFFFF;
    logic [23:0] rgb_out;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_ACTIVE_HIGH(HSH), .VS_ACTIVE_HIGH(VSH),
        .PIPE_LAT(LAT)
    ) dut (
        .clk_pixel(clk), .rst_n(rst_n), .enable(enable),
        .req(req), .x(x), .y(y), .sof(sof), .sol(sol),
        .rgb_in(rgb_in), .rgb_out(rgb_out),
        .hsync(hsync), .vsync(vsync), .de(de),
        .running(running), .frame_count(frame_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h",
                     nm, $time, a, e);
        end
    endtask

    function automatic logic [23:0] pix(input int px, input int py);
        logic [31:0] a, b;
        a = px;
        b = py;
        return {a[7:0], b[7:0], 8'hA5};
    endfunction

    // Pixel source: answers a request LAT cycles later, white otherwise.
    typedef struct {
        bit         r;
        logic [9:0] sx;
        logic [9:0] sy;
    } src_t;
    src_t sh[LAT+1];

    always @(posedge clk) begin
        #1;
        for (int k = LAT; k >= 1; k--) sh[k] = sh[k-1];
        sh[0] = '{req === 1'b1, x, y};
        rgb_in = sh[LAT].r ? {sh[LAT].sx[7:0], sh[LAT].sy[7:0], 8'hA5}
                           : 24'hFFFFFF;
    end

    // Reference model: mode 0 idle, 1 run, 2 stopping; pos is the
    // linear index of the next position to issue within the frame.
    typedef struct {
        bit act;
        bit hs;
        bit vs;
        int px;
        int py;
    } ent_t;

    int         m_mode, m_pos, m_fc;
    int         m_x, m_y;
    ent_t       mq[$];
    bit         e_req, e_sof, e_sol;
    ent_t       o;

    bit win = 1'b0;
    int c_req, c_sof, c_sol, c_de, c_hs, c_vs;

    task automatic model_reset();
        ent_t b;
        b = '{0, 0, 0, 0, 0};
        m_mode = 0;
        m_pos = 0;
        m_fc = 0;
        m_x = 0;
        m_y = 0;
        mq.delete();
        for (int k = 0; k <= LAT; k++) mq.push_back(b);
    endtask

    task automatic model_step(input bit en);
        ent_t n;
        int   h, v;
        bit   last;
        n = '{0, 0, 0, 0, 0};
        last = 0;
        if (m_mode != 0 || en) begin
            h = m_pos % HT;
            v = m_pos / HT;
            e_req = (h < HA) && (v < VA);
            e_sof = (m_pos == 0);
            e_sol = (h == 0);
            m_x = h;
            m_y = v;
            n.act = e_req;
            n.hs = (h >= HA + HFP) && (h < HA + HFP + HS);
            n.vs = (v >= VA + VFP) && (v < VA + VFP + VS);
            n.px = h;
            n.py = v;
            last = (m_pos == FR - 1);
            if (last) m_fc = (m_fc + 1) % 65536;
            m_pos = last ? 0 : m_pos + 1;
        end else begin
            e_req = 0;
            e_sof = 0;
            e_sol = 0;
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = 2;
            default: begin
                if (en) m_mode = 1;
                else if (last) m_mode = 0;
            end
        endcase
        mq.push_back(n);
        o = mq.pop_front();
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            model_reset();
            e_req = 0;
            e_sof = 0;
            e_sol = 0;
            o = '{0, 0, 0, 0, 0};
        end else begin
            model_step(enable);
        end
        check("req", req, e_req);
        check("x", x, m_x);
        check("y", y, m_y);
        check("sof", sof, e_sof);
        check("sol", sol, e_sol);
        check("de", de, o.act);
        check("hsync", hsync, HSH ? o.hs : !o.hs);
        check("vsync", vsync, VSH ? o.vs : !o.vs);
        check("rgb_out", rgb_out, o.act ? pix(o.px, o.py) : 24'h0);
        check("running", running, m_mode != 0);
        check("frame_count", frame_count, m_fc);
        if (win) begin
            c_req += int'(req);
            c_sof += int'(sof);
            c_sol += int'(sol);
            c_de  += int'(de);
            c_hs  += int'(hsync == HSH);
            c_vs  += int'(vsync == VSH);
        end
    end

    task automatic wait_pos(input int t);
        int n;
        n = 0;
        while (m_pos != t && n < 4 * FR) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos", m_pos, t);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, req, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_hsync"}, hsync, !HSH);
        check({tag, "_vsync"}, vsync, !VSH);
        check({tag, "_rgb"}, rgb_out, 0);
        check({tag, "_fc"}, frame_count, 0);
        check({tag, "_running"}, running, 0);
    endtask

    initial begin
        int cnt;
        // Reset held with enable already high: everything stays blank.
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");

        c_req = 0; c_sof = 0; c_sol = 0;
        c_de = 0; c_hs = 0; c_vs = 0;
        rst_n = 1'b1;
        win = 1'b1;
        @(posedge clk);
        #2;
        check("first_req", req, 1);
        check("first_x", x, 0);
        check("first_y", y, 0);
        check("first_sof", sof, 1);
        repeat (2 * FR) @(negedge clk);
        win = 1'b0;
        check("geo_req", c_req, 2 * HA * VA);
        check("geo_sof", c_sof, 2);
        check("geo_sol", c_sol, 2 * VT);
        check("geo_de", c_de, 2 * HA * VA);
        check("geo_hsync", c_hs, 2 * HS * VT);
        check("geo_vsync", c_vs, 2 * VS * HT);
        check("geo_fc", frame_count, 2);

        // Stop mid-frame: the frame runs to its last position.
        wait_pos(4 * HT + 5);
        enable = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (running && cnt < 2 * FR);
        check("stop_cycles", cnt, FR - (4 * HT + 5));
        repeat (20) @(negedge clk);
        check("idle_req", req, 0);
        check("idle_de", de, 0);
        check("idle_fc", frame_count, 3);

        // Stop then re-raise while stopping: no gap, one sof per frame.
        enable = 1'b1;
        wait_pos(4 * HT + 5);
        enable = 1'b0;
        wait_pos(9 * HT + 10);
        enable = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!sof && cnt < 2 * FR);
        check("restart_sof_gap", cnt, FR - (9 * HT + 10) + 1);

        // Asynchronous reset mid-frame.
        wait_pos(4 * HT + 8);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("rst_sof", sof, 1);
        check("rst_x", x, 0);
        check("rst_y", y, 0);

        // Random enable toggling with occasional resets.
        repeat (8000) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
